// File: rtl/bicubic_dsp_add_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bicubic_dsp_add_ctrl_if                                      |
// | Description : Operand/result handshake bundle between the bicubic DSP      |
// |               adder-array sequencer and its upstream/downstream neighbours.|
// |               Upstream side (s_*): s_valid, s_last in; s_ready out.        |
// |               Downstream side (m_*): m_valid, m_last out; m_ready in.      |
// |               Modport slave  : controller view (bicubic_dsp_add_ctrl).     |
// |               Modport master : environment view (source + sink).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bicubic_dsp_add_ctrl_if;
   logic s_valid;
   logic s_ready;
   logic s_last;
   logic m_valid;
   logic m_ready;
   logic m_last;

   modport slave (
      input  s_valid,
      input  s_last,
      output s_ready,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport master (
      output s_valid,
      output s_last,
      input  s_ready,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface
`default_nettype wire

// File: rtl/bicubic_dsp_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bicubic_dsp_add_ctrl                                         |
// | Description : Sequencer for the bicubic Nx DSP 8-input adder array. Owns   |
// |               the array clock-enable and DSP reset, tracks beat-valid and  |
// |               frame-last through the fixed DSP latency, and freezes the    |
// |               whole array on downstream backpressure.                      |
// | Ports       : clk        - core clock, rising edge                         |
// |               aresetn    - synchronous active-low reset                    |
// |               bus        - handshake bundle (slave modport)                |
// |               dsp_clken  - adder array clock enable                        |
// |               dsp_reset  - adder array register clear                      |
// |               busy       - not in RUN, or any beat in flight               |
// |               stat_beats / stat_stalls - present only when the macro       |
// |               BICUBIC_DSP_CTRL_STAT_EN is defined                          |
// | Parameters  : DSP_LATENCY (>=1), INIT_CYCLES (>=1)                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bicubic_dsp_add_ctrl #(
   parameter int DSP_LATENCY = 4,
   parameter int INIT_CYCLES = 3
) (
   input  wire                    clk,
   input  wire                    aresetn,
   bicubic_dsp_add_ctrl_if.slave  bus,
   output logic                   dsp_clken,
   output logic                   dsp_reset,
   output logic                   busy
`ifdef BICUBIC_DSP_CTRL_STAT_EN
   ,
   output logic [31:0]            stat_beats,
   output logic [31:0]            stat_stalls
`endif
);

   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(INIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic [DSP_LATENCY-1:0]  vld;
   logic [DSP_LATENCY-1:0]  lst;
   logic [DSP_LATENCY-1:0]  vld_shift;
   logic [DSP_LATENCY-1:0]  lst_shift;
   logic                    stall;
   logic                    s_ready_int;
   logic                    accept;
   logic                    out_xfer;

   // Result side is read straight from the last pipeline stage so that it
   // holds automatically whenever clken is low.
   assign bus.m_valid = vld[DSP_LATENCY-1];
   assign bus.m_last  = lst[DSP_LATENCY-1];
   assign bus.s_ready = s_ready_int;

   assign stall    = bus.m_valid & ~bus.m_ready;
   assign accept   = bus.s_valid & s_ready_int;
   assign out_xfer = bus.m_valid & bus.m_ready;
   assign busy     = (state != ST_RUN) | (|vld);

   // Next-state and control outputs
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      dsp_clken   = 1'b1;
      dsp_reset   = 1'b0;
      s_ready_int = 1'b0;
      case (state)
         ST_INIT: begin
            dsp_reset = 1'b1;
            if (cnt == C_CNT_LAST) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // s_ready follows m_ready combinationally so a stalled array
            // never captures a new operand.
            dsp_clken   = ~stall;
            s_ready_int = ~stall;
            if (bus.s_valid & ~stall & bus.s_last) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            dsp_clken = ~stall;
            if (out_xfer & bus.m_last) begin
               state_nxt = ST_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Shifted pipeline image; outside RUN accept is 0 so bubbles enter stage 0.
   always_comb begin
      vld_shift    = '0;
      lst_shift    = '0;
      vld_shift[0] = accept;
      lst_shift[0] = accept & bus.s_last;
      for (int i = 1; i < DSP_LATENCY; i++) begin
         vld_shift[i] = vld[i-1];
         lst_shift[i] = lst[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state <= ST_INIT;
         cnt   <= '0;
         vld   <= '0;
         lst   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (dsp_clken) begin
            vld <= vld_shift;
            lst <= lst_shift;
         end
      end
   end

`ifdef BICUBIC_DSP_CTRL_STAT_EN
   // Running statistics; wrap naturally and survive frame boundaries.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         stat_beats  <= '0;
         stat_stalls <= '0;
      end else begin
         if (out_xfer) begin
            stat_beats <= stat_beats + 32'd1;
         end
         if (stall) begin
            stat_stalls <= stat_stalls + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bicubic_dsp_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bicubic_dsp_add_ctrl                                      |
// | Description : Self-checking bench for bicubic_dsp_add_ctrl. Directed       |
// |               timing checks plus a last-flag scoreboard: accepted beats    |
// |               are queued by the driver, results are popped by a monitor.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bicubic_dsp_add_ctrl;

   localparam int DSP_LATENCY = 4;
   localparam int INIT_CYCLES = 3;
   localparam int N_RAND      = 1000;

   logic clk     = 1'b0;
   logic aresetn = 1'b0;
   logic dsp_clken;
   logic dsp_reset;
   logic busy;
`ifdef BICUBIC_DSP_CTRL_STAT_EN
   logic [31:0] stat_beats;
   logic [31:0] stat_stalls;
`endif

   bicubic_dsp_add_ctrl_if bus ();

   bicubic_dsp_add_ctrl #(
      .DSP_LATENCY (DSP_LATENCY),
      .INIT_CYCLES (INIT_CYCLES)
   ) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .bus         (bus),
      .dsp_clken   (dsp_clken),
      .dsp_reset   (dsp_reset),
      .busy        (busy)
`ifdef BICUBIC_DSP_CTRL_STAT_EN
      ,
      .stat_beats  (stat_beats),
      .stat_stalls (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp       = 0;
   int n_bad       = 0;
   int n_pushed    = 0;
   int n_popped    = 0;
   int n_discarded = 0;
   bit exp_q[$];
   bit acc_flag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Wait for the sampling edge and record an accepted beat in the scoreboard.
   task automatic to_neg();
      @(negedge clk);
      acc_flag = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
      if (acc_flag) begin
         exp_q.push_back(bus.s_last);
         n_pushed++;
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every result transfer must match the oldest accepted beat.
   always @(negedge clk) begin : monitor
      bit e;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
         n_popped++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got result with m_last=%0b expected none (t=%0t)",
                     bus.m_last, $time);
         end else begin
            e = exp_q.pop_front();
            if (bus.m_last !== e) begin
               n_bad++;
               $display("FAIL m_last_order: got %0b expected %0b (t=%0t)", bus.m_last, e, $time);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stim
      int     sent;
      int     bif;
      int     flen;
      int     guard;
      int     p0;
      logic [31:0] st0;

      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;
      aresetn     = 1'b0;
      st0         = '0;

      // ---- 1: reset values and INIT length ----
      to_neg();
      check("rst_s_ready",   bus.s_ready, 0);
      check("rst_m_valid",   bus.m_valid, 0);
      check("rst_m_last",    bus.m_last,  0);
      check("rst_dsp_clken", dsp_clken,   1);
      check("rst_dsp_reset", dsp_reset,   1);
      check("rst_busy",      busy,        1);
      to_pos();
      aresetn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         to_neg();
         check($sformatf("t1_dsp_reset[%0d]", i), dsp_reset,   (i <= 3) ? 1 : 0);
         check($sformatf("t1_s_ready[%0d]", i),   bus.s_ready, (i == 4) ? 1 : 0);
         check($sformatf("t1_m_valid[%0d]", i),   bus.m_valid, 0);
         if (i == 4) check("t1_busy_idle", busy, 0);
         to_pos();
      end

      // ---- 2: 8-beat frame, no backpressure ----
      for (int i = 0; i <= 15; i++) begin
         bus.s_valid = (i < 8);
         bus.s_last  = (i == 7);
         bus.m_ready = 1'b1;
         to_neg();
         check($sformatf("t2_m_valid[%0d]", i),   bus.m_valid, (i >= 4 && i <= 11) ? 1 : 0);
         check($sformatf("t2_m_last[%0d]", i),    bus.m_last,  (i == 11) ? 1 : 0);
         check($sformatf("t2_s_ready[%0d]", i),   bus.s_ready, (i <= 7 || i == 15) ? 1 : 0);
         check($sformatf("t2_dsp_reset[%0d]", i), dsp_reset,   (i >= 12 && i <= 14) ? 1 : 0);
         to_pos();
      end

      // ---- 3: five-cycle downstream stall mid-frame ----
`ifdef BICUBIC_DSP_CTRL_STAT_EN
      st0 = stat_stalls;
`endif
      sent = 0;
      for (int i = 0; i < 30; i++) begin
         bus.s_valid = (sent < 8);
         bus.s_last  = (sent == 7);
         bus.m_ready = !(i >= 6 && i <= 10);
         to_neg();
         if (acc_flag) sent++;
         if (i >= 5 && i <= 11) begin
            check($sformatf("t3_dsp_clken[%0d]", i), dsp_clken,   (i >= 6 && i <= 10) ? 0 : 1);
            check($sformatf("t3_s_ready[%0d]", i),   bus.s_ready, (i >= 6 && i <= 10) ? 0 : 1);
         end
         if (i == 8) check("t3_m_valid_hold", bus.m_valid, 1);
         to_pos();
      end
      check("t3_sent", sent, 8);
`ifdef BICUBIC_DSP_CTRL_STAT_EN
      check("t3_stat_stalls", stat_stalls - st0, 5);
`endif

      // ---- 4: single-beat frame ----
      for (int i = 0; i <= 8; i++) begin
         bus.s_valid = (i == 0);
         bus.s_last  = (i == 0);
         bus.m_ready = 1'b1;
         to_neg();
         if (i == 0) check("t4_s_ready_run", bus.s_ready, 1);
         if (i >= 1 && i <= 3) begin
            check($sformatf("t4_flush_s_ready[%0d]", i), bus.s_ready, 0);
            check($sformatf("t4_flush_busy[%0d]", i),    busy,        1);
         end
         check($sformatf("t4_m_valid[%0d]", i),   bus.m_valid, (i == 4) ? 1 : 0);
         check($sformatf("t4_m_last[%0d]", i),    bus.m_last,  (i == 4) ? 1 : 0);
         check($sformatf("t4_dsp_reset[%0d]", i), dsp_reset,   (i >= 5 && i <= 7) ? 1 : 0);
         if (i == 8) check("t4_s_ready_back", bus.s_ready, 1);
         to_pos();
      end

      // ---- 5: reset with three beats in flight ----
      for (int i = 0; i <= 12; i++) begin
         bus.s_valid = (i < 3);
         bus.s_last  = 1'b0;
         bus.m_ready = 1'b1;
         aresetn     = (i != 3);
         to_neg();
         if (i == 3) check("t5_inflight", exp_q.size(), 3);
         if (i >= 4) begin
            check($sformatf("t5_m_valid[%0d]", i),   bus.m_valid, 0);
            check($sformatf("t5_dsp_reset[%0d]", i), dsp_reset,   (i <= 6) ? 1 : 0);
         end
         if (i == 4) begin
            check("t5_busy", busy, 1);
`ifdef BICUBIC_DSP_CTRL_STAT_EN
            check("t5_stat_beats_clr",  stat_beats,  0);
            check("t5_stat_stalls_clr", stat_stalls, 0);
`endif
         end
         if (i == 7) check("t5_s_ready", bus.s_ready, 1);
         to_pos();
         if (i == 3) begin
            n_discarded += exp_q.size();
            exp_q.delete();
         end
      end

      // ---- 6: random valid/ready traffic against the scoreboard ----
      p0    = n_popped;
      sent  = 0;
      bif   = 0;
      flen  = $urandom_range(1, 16);
      guard = 0;
      while (sent < N_RAND && guard < 20000) begin
         bus.s_valid = ($urandom_range(0, 3) != 0);
         if (bus.s_valid)
            bus.s_last = (bif == flen - 1) || (sent == N_RAND - 1);
         else
            bus.s_last = 1'($urandom_range(0, 1));
         bus.m_ready = ($urandom_range(0, 2) != 0);
         to_neg();
         if (acc_flag) begin
            sent++;
            if (bus.s_last) begin
               bif  = 0;
               flen = $urandom_range(1, 16);
            end else begin
               bif++;
            end
         end
         to_pos();
         guard++;
      end
      check("t6_sent", sent, N_RAND);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         to_neg();
         to_pos();
         guard++;
      end
      check("t6_drained", exp_q.size(), 0);
      check("t6_popped", n_popped - p0, N_RAND);
`ifdef BICUBIC_DSP_CTRL_STAT_EN
      check("t6_stat_beats", stat_beats, N_RAND);
`endif
      check("total_balance", n_popped, n_pushed - n_discarded);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
